// File: rtl/rv_pkg.sv
// Shared integer-pipeline types: data width, register count, writeback request.
// Latency: none (types and constants only).
// Backpressure: none.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xword_t    data;
  } wb_req_t;

endpackage

// File: rtl/wb_load_queue.sv
// Small synchronous FIFO holding load responses that lost the write port to the ALU.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: pushes are ignored while full, pops are ignored while empty.
module wb_load_queue #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [4:0]    push_rd_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [4:0]    head_rd_o,
  output logic [DW-1:0] head_data_o
);
  import rv_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  reg_addr_t     rd_mem_q   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;

  // Pointer and occupancy tracking; wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: stale slots are never read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU (priority, never stalls) and queued loads share the regfile write port; tracks busy regs.
// Latency: 1 cycle from ALU result or unqueued load handshake to RegWrite; queued loads drain in order.
// Backpressure: ld_ready drops when the load queue is full (registered count only). Option macro: WB_FWD_EN.
module wb_arbiter #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NREGS    = rv_pkg::NREGS,
  parameter int LQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_is_load,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       q_rs1,
  input  logic [4:0]       q_rs2,
  output logic             hazard,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [XLEN-1:0]  ld_data,
`ifdef WB_FWD_EN
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd_data,
`endif
  output logic             RegWrite,
  output logic [4:0]       as3,
  output logic [XLEN-1:0]  ALUout,
  output logic [NREGS-1:0] busy
);
  import rv_pkg::*;

  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam logic [CW-1:0] LQ_MAX = CW'(LQ_DEPTH);

  wb_req_t          sel;
  logic             sel_is_load;
  logic             alu_w, ld_acc, bypass;
  logic             lq_push, lq_pop, lq_full, lq_empty;
  logic [CW-1:0]    lq_count;
  logic [4:0]       lq_head_rd;
  logic [XLEN-1:0]  lq_head_data;

  logic             wr_en_q;
  logic [4:0]       wr_addr_q;
  logic [XLEN-1:0]  wr_data_q;
  logic [NREGS-1:0] busy_d, busy_q;

  assign alu_w    = alu_valid && (alu_rd != '0);
  assign ld_ready = (lq_count < LQ_MAX);
  assign ld_acc   = ld_valid && ld_ready;
  assign lq_push  = ld_acc && !bypass && !lq_full;

  wb_load_queue #(
    .DEPTH (LQ_DEPTH),
    .DW    (XLEN)
  ) u_lq (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (lq_push),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (lq_pop),
    .full_o      (lq_full),
    .empty_o     (lq_empty),
    .count_o     (lq_count),
    .head_rd_o   (lq_head_rd),
    .head_data_o (lq_head_data)
  );

  // Pick the write for this cycle: ALU first, then queue head, then a same-cycle load bypass.
  // A load to x0 still occupies its slot but produces no write.
  always_comb begin
    sel         = '0;
    sel_is_load = 1'b0;
    lq_pop      = 1'b0;
    bypass      = 1'b0;
    if (alu_w) begin
      sel.valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end else if (!lq_empty) begin
      lq_pop      = 1'b1;
      sel.valid   = (lq_head_rd != '0);
      sel.rd      = lq_head_rd;
      sel.data    = lq_head_data;
      sel_is_load = 1'b1;
    end else if (ld_acc) begin
      bypass      = 1'b1;
      sel.valid   = (ld_rd != '0);
      sel.rd      = ld_rd;
      sel.data    = ld_data;
      sel_is_load = 1'b1;
    end
  end

  // Write-port register; address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= sel.valid;
      if (sel.valid) begin
        wr_addr_q <= sel.rd;
        wr_data_q <= sel.data;
      end
    end
  end

`ifndef WB_FWD_EN
  logic last_load_q;

  // Remembers that the write now on the port came from a load, so its busy bit clears next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_load_q <= 1'b0;
    else        last_load_q <= sel.valid && sel_is_load;
  end
`endif

  // Scoreboard next state: clear on load writeback, then set on load issue so set wins.
  always_comb begin
    busy_d = busy_q;
`ifdef WB_FWD_EN
    if (sel.valid && sel_is_load) busy_d[sel.rd] = 1'b0;
`else
    if (last_load_q) busy_d[wr_addr_q] = 1'b0;
`endif
    if (issue_valid && issue_is_load && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign hazard   = busy_q[q_rs1] | busy_q[q_rs2] | busy_q[issue_rd];
  assign RegWrite = wr_en_q;
  assign as3      = wr_addr_q;
  assign ALUout   = wr_data_q;
  assign busy     = busy_q;

`ifdef WB_FWD_EN
  assign fwd1_hit = wr_en_q && (wr_addr_q != '0) && (wr_addr_q == q_rs1);
  assign fwd2_hit = wr_en_q && (wr_addr_q != '0) && (wr_addr_q == q_rs2);
  assign fwd_data = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, scoreboard, conflict/backpressure, mid-run reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after.
// Option macro: WB_FWD_EN (adds forward-path checks and earlier scoreboard clear).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rd, q_rs1, q_rs2;
  logic        hazard;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        RegWrite;
  logic [4:0]  as3;
  logic [31:0] ALUout;
  logic [31:0] busy;
`ifdef WB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_is_load (issue_is_load),
    .issue_rd      (issue_rd),
    .q_rs1         (q_rs1),
    .q_rs2         (q_rs2),
    .hazard        (hazard),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
`ifdef WB_FWD_EN
    .fwd1_hit      (fwd1_hit),
    .fwd2_hit      (fwd2_hit),
    .fwd_data      (fwd_data),
`endif
    .RegWrite      (RegWrite),
    .as3           (as3),
    .ALUout        (ALUout),
    .busy          (busy)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rst_busy: got %h want 0", busy); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Put a write on the port, then reset mid-cycle and expect immediate clearing.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0666;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL pre_rst_write: got %b want 1", RegWrite); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL async_rst_regwrite: got %b want 0", RegWrite); end
    total++; if (as3 !== 5'd0) begin bad++; $display("FAIL async_rst_as3: got %0d want 0", as3); end
    total++; if (ALUout !== 32'h0) begin bad++; $display("FAIL async_rst_aluout: got %h want 0", ALUout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_path();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL alu_regwrite: got %b want 1", RegWrite); end
    total++; if (as3 !== 5'd5) begin bad++; $display("FAIL alu_as3: got %0d want 5", as3); end
    total++; if (ALUout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_data: got %h want deadbeef", ALUout); end
    alu_rd = 5'd0; alu_data = 32'h0000_1111;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL alu_x0_regwrite: got %b want 0", RegWrite); end
    total++; if (as3 !== 5'd5) begin bad++; $display("FAIL alu_x0_as3_hold: got %0d want 5", as3); end
    total++; if (ALUout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_x0_data_hold: got %h want deadbeef", ALUout); end
  endtask

  task automatic test_load_scoreboard();
    @(negedge clk);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_set: got %h want 00000080", busy); end
    q_rs1 = 5'd7; #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_raw_hazard: got %b want 1", hazard); end
    q_rs1 = 5'd0; issue_rd = 5'd7; #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_waw_hazard: got %b want 1", hazard); end
    issue_rd = 5'd0; #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL sb_no_hazard: got %b want 0", hazard); end
    q_rs1 = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_1234; #1;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_empty: got %b want 1", ld_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    total++; if (RegWrite !== 1'b1 || as3 !== 5'd7 || ALUout !== 32'h0000_1234)
      begin bad++; $display("FAIL ld_bypass_write: got %b/%0d/%h want 1/7/00001234", RegWrite, as3, ALUout); end
    total++; if (busy[7] !== !FWD) begin bad++; $display("FAIL sb_clear_timing: got %b want %b", busy[7], !FWD); end
    total++; if (hazard !== !FWD) begin bad++; $display("FAIL sb_hazard_timing: got %b want %b", hazard, !FWD); end
`ifdef WB_FWD_EN
    total++; if (fwd1_hit !== 1'b1) begin bad++; $display("FAIL fwd_ld_hit: got %b want 1", fwd1_hit); end
`endif
    @(negedge clk);
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_cleared: got %h want 0", busy); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL ld_single_write: got %b want 0", RegWrite); end
    q_rs1 = 5'd0;
    // A load to x0 is accepted but never written.
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_0055;
    @(negedge clk);
    ld_valid = 1'b0;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL ld_x0_nowrite: got %b want 0", RegWrite); end
    total++; if (as3 !== 5'd7) begin bad++; $display("FAIL ld_x0_as3_hold: got %0d want 7", as3); end
  endtask

  task automatic test_conflict_backpressure();
    logic [4:0]  exp_rd   [7];
    logic [31:0] exp_dat  [7];
    exp_rd  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd4, 5'd0};
    exp_dat = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hA, 32'hB, 32'h0};
    @(negedge clk);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    issue_rd = 5'd4;
    @(negedge clk);
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    total++; if (busy !== 32'h0000_0018) begin bad++; $display("FAIL cf_busy_set: got %h want 00000018", busy); end
    for (int c = 0; c < 7; c++) begin
      alu_valid = (c < 4);
      alu_rd    = 5'd10 + 5'(c);
      alu_data  = 32'h100 + 32'(c);
      ld_valid  = (c < 2);
      ld_rd     = (c == 0) ? 5'd3 : 5'd4;
      ld_data   = (c == 0) ? 32'hA : 32'hB;
      #1;
      if (c == 2) begin
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL cf_ld_ready_full: got %b want 0", ld_ready); end
      end
      @(negedge clk);
      total++; if (RegWrite !== (c < 6)) begin bad++; $display("FAIL cf_regwrite[%0d]: got %b want %b", c, RegWrite, (c < 6)); end
      if (c < 6) begin
        total++; if (as3 !== exp_rd[c] || ALUout !== exp_dat[c])
          begin bad++; $display("FAIL cf_order[%0d]: got %0d/%h want %0d/%h", c, as3, ALUout, exp_rd[c], exp_dat[c]); end
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL cf_busy_cleared: got %h want 0", busy); end
  endtask

  task automatic test_reset_mid_operation();
    @(negedge clk);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    issue_rd = 5'd4;
    @(negedge clk);
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA;
    @(negedge clk);
    alu_rd = 5'd21; alu_data = 32'h21;
    ld_rd = 5'd4; ld_data = 32'hB;
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    total++; if (busy !== 32'h0000_0018) begin bad++; $display("FAIL rm_busy_before: got %h want 00000018", busy); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rm_queue_full: got %b want 0", ld_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rm_busy_reset: got %h want 0", busy); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rm_ld_ready_reset: got %b want 1", ld_ready); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rm_regwrite_reset: got %b want 0", RegWrite); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rm_no_write[%0d]: got %b want 0", c, RegWrite); end
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
    q_rs1 = 5'd2; q_rs2 = 5'd9;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (fwd2_hit !== 1'b1) begin bad++; $display("FAIL fwd2_hit: got %b want 1", fwd2_hit); end
    total++; if (fwd1_hit !== 1'b0) begin bad++; $display("FAIL fwd1_miss: got %b want 0", fwd1_hit); end
    total++; if (fwd_data !== 32'h0000_0099) begin bad++; $display("FAIL fwd_data: got %h want 00000099", fwd_data); end
    @(negedge clk);
    total++; if (fwd2_hit !== 1'b0) begin bad++; $display("FAIL fwd2_idle: got %b want 0", fwd2_hit); end
    q_rs1 = 5'd0; q_rs2 = 5'd0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
    test_reset();
    test_alu_path();
    test_load_scoreboard();
    test_conflict_backpressure();
    test_reset_mid_operation();
`ifdef WB_FWD_EN
    test_forward();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
